// File: rtl/apb_gpio_arbiter.sv
// Two-requester APB master sharing the GPIO slave; round-robin arbitration by default,
// fixed priority to requester 0 when GPIO_ARB_FIXED_PRIO_EN is defined.
module apb_gpio_arbiter #(
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 16,
    parameter logic [ADDR_W-1:0]  TRIS_ADDR = 5'b11110,
    parameter logic [ADDR_W-1:0]  PORT_ADDR = 5'b11111
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state, state_next;
    logic              grant;
    logic              grant_next;
    logic              any_valid;
    logic              legal_next;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifndef GPIO_ARB_FIXED_PRIO_EN
    logic              rr_last;
`endif

    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef GPIO_ARB_FIXED_PRIO_EN
        grant_next = req0_valid ? 1'b0 : 1'b1;
`else
        if (req0_valid && req1_valid) grant_next = ~rr_last;
        else                          grant_next = ~req0_valid;
`endif
        sel_write  = grant_next ? req1_write : req0_write;
        sel_addr   = grant_next ? req1_addr  : req0_addr;
        sel_wdata  = grant_next ? req1_wdata : req0_wdata;
        // TRIS is write-only; anything outside TRIS/PORT never reaches the bus
        legal_next = (sel_addr == PORT_ADDR) || ((sel_addr == TRIS_ADDR) && sel_write);

        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = legal_next ? SETUP : DONE;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            grant      <= 1'b0;
`ifndef GPIO_ARB_FIXED_PRIO_EN
            rr_last    <= 1'b1;
`endif
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req0_ready <= 1'b0;
            req0_err   <= 1'b0;
            req0_rdata <= '0;
            req1_ready <= 1'b0;
            req1_err   <= 1'b0;
            req1_rdata <= '0;
        end else begin
            req0_ready <= 1'b0;
            req0_err   <= 1'b0;
            req1_ready <= 1'b0;
            req1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant   <= grant_next;
`ifndef GPIO_ARB_FIXED_PRIO_EN
                        rr_last <= grant_next;
`endif
                        if (legal_next) begin
                            PSEL   <= 1'b1;
                            PWRITE <= sel_write;
                            PADDR  <= sel_addr;
                            PWDATA <= sel_wdata;
                        end else if (grant_next) begin
                            req1_ready <= 1'b1;
                            req1_err   <= 1'b1;
                        end else begin
                            req0_ready <= 1'b1;
                            req0_err   <= 1'b1;
                        end
                    end
                end
                SETUP: PENABLE <= 1'b1;
                ACCESS: begin
                    // GPIO has no PREADY, so the access phase always ends here
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (grant) begin
                        req1_ready <= 1'b1;
                        if (!PWRITE) req1_rdata <= PRDATA;
                    end else begin
                        req0_ready <= 1'b1;
                        if (!PWRITE) req0_rdata <= PRDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
